dual_port_memory_reader: RTL and testbench

- Read-side initiator for the instruction cache's dual-port line memory.
- Converts a valid/ready address request stream into memory read strobes and tracks the memory's fixed read latency (1 cycle low-latency build, 2 cycles high-performance build).
- Returns line data in order on a valid/ready response stream, with a credit-limited skid buffer absorbing downstream backpressure.
- Supports a single-cycle flush that discards all outstanding and buffered reads.

---
 rtl/dual_port_memory_reader.sv | 116 +++++++++++
 tb/tb_dual_port_memory_reader.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/dual_port_memory_reader.sv
// Read-side initiator for the instruction cache line memory: issues read strobes, tracks the
// fixed read latency and returns lines in order through a credit-limited skid buffer.
// Optional address echo on the response side: define DUAL_PORT_MEMORY_READER_ADDR_ECHO_EN.
module dual_port_memory_reader #(
  parameter int MEMORY_WIDTH = 512,
  parameter int MEMORY_DEPTH = 512,
  parameter int READ_LATENCY = 2,
  parameter int BUFFER_DEPTH = 4,
  localparam int ADDRESS_WIDTH = $clog2(MEMORY_DEPTH-1)
) (
  input  logic                     CLK,
  input  logic                     RSTN,
  input  logic                     FLUSH,
  input  logic                     REQ_VALID,
  output logic                     REQ_READY,
  input  logic [ADDRESS_WIDTH-1:0] REQ_ADDRESS,
  output logic [ADDRESS_WIDTH-1:0] MEM_READ_ADDRESS,
  output logic                     MEM_READ_ENBLE,
  input  logic [MEMORY_WIDTH-1:0]  MEM_DATA_OUT,
  output logic                     RSP_VALID,
  input  logic                     RSP_READY,
  output logic [MEMORY_WIDTH-1:0]  RSP_DATA
`ifdef DUAL_PORT_MEMORY_READER_ADDR_ECHO_EN
  ,
  output logic [ADDRESS_WIDTH-1:0] RSP_ADDRESS
`endif
);

  localparam int PTR_W = $clog2(BUFFER_DEPTH);
  localparam int CNT_W = $clog2(BUFFER_DEPTH + 1);

  if (READ_LATENCY < 1 || READ_LATENCY > 2) begin : g_bad_latency
    $error("dual_port_memory_reader: READ_LATENCY must be 1 or 2");
  end
  if (BUFFER_DEPTH < READ_LATENCY + 1) begin : g_bad_depth
    $error("dual_port_memory_reader: BUFFER_DEPTH must be at least READ_LATENCY+1");
  end

  logic [CNT_W-1:0]        used_q;
  logic [CNT_W-1:0]        occ_q;
  logic [PTR_W-1:0]        head_q;
  logic [PTR_W-1:0]        tail_q;
  logic [READ_LATENCY-1:0] vpipe_q;
  logic [READ_LATENCY-1:0] vpipe_next;
  logic [MEMORY_WIDTH-1:0] data_mem [BUFFER_DEPTH];

  logic accept;
  logic pop;
  logic wr;
  logic clear;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    // Depth need not be a power of two, so wrap on the last index rather than on overflow.
    return (p == PTR_W'(BUFFER_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Credits come from the registered counter; only the live reset/flush inputs gate them further.
  assign REQ_READY        = RSTN & ~FLUSH & (used_q < CNT_W'(BUFFER_DEPTH));
  assign accept           = REQ_VALID & REQ_READY;
  assign MEM_READ_ENBLE   = accept;
  assign MEM_READ_ADDRESS = REQ_ADDRESS;

  assign RSP_VALID = RSTN & (occ_q != '0);
  assign RSP_DATA  = data_mem[head_q];
  assign pop       = RSP_VALID & RSP_READY;
  assign clear     = ~RSTN | FLUSH;
  assign wr        = vpipe_q[READ_LATENCY-1] & ~clear;

  if (READ_LATENCY == 1) begin : g_pipe1
    assign vpipe_next = accept;
  end else begin : g_pipe_n
    assign vpipe_next = {vpipe_q[READ_LATENCY-2:0], accept};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (clear) begin
      vpipe_q <= '0;
      used_q  <= '0;
      occ_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      vpipe_q <= vpipe_next;
      used_q  <= used_q + CNT_W'(accept) - CNT_W'(pop);
      occ_q   <= occ_q + CNT_W'(wr) - CNT_W'(pop);
      if (wr)  tail_q <= ptr_inc(tail_q);
      if (pop) head_q <= ptr_inc(head_q);
    end
  end

  // NOTE: line storage carries no reset; occupancy alone decides whether an entry is meaningful.
  always_ff @(posedge CLK) begin
    if (wr) data_mem[tail_q] <= MEM_DATA_OUT;
  end

`ifdef DUAL_PORT_MEMORY_READER_ADDR_ECHO_EN
  logic [ADDRESS_WIDTH-1:0] apipe_q  [READ_LATENCY];
  logic [ADDRESS_WIDTH-1:0] addr_mem [BUFFER_DEPTH];

  // Addresses are narrow, so they are reset to give a defined RSP_ADDRESS of zero after reset.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      for (int i = 0; i < READ_LATENCY; i++) apipe_q[i]  <= '0;
      for (int i = 0; i < BUFFER_DEPTH; i++) addr_mem[i] <= '0;
    end else begin
      apipe_q[0] <= REQ_ADDRESS;
      for (int i = 1; i < READ_LATENCY; i++) apipe_q[i] <= apipe_q[i-1];
      if (wr) addr_mem[tail_q] <= apipe_q[READ_LATENCY-1];
    end
  end

  assign RSP_ADDRESS = addr_mem[head_q];
`endif

endmodule

// File: tb/tb_dual_port_memory_reader.sv
// Self-checking bench: two reader builds (latency 2/depth 4 and latency 1/depth 3) share one
// stimulus stream and are each checked every cycle against a transaction-level scoreboard.
module tb_dual_port_memory_reader;

  localparam int AW = 9;
  localparam int DW = 512;
  localparam int LAT   [2] = '{2, 1};
  localparam int DEPTH [2] = '{4, 3};

  typedef struct {
    logic [AW-1:0] addr;
    int            avail;
  } ent_t;

  logic          clk = 1'b0;
  logic          rstn;
  logic          flush;
  logic          req_valid;
  logic [AW-1:0] req_address;
  logic          rsp_ready;

  logic          req_ready [2];
  logic [AW-1:0] mem_addr  [2];
  logic          mem_en    [2];
  logic [DW-1:0] mem_dout  [2];
  logic          rsp_valid [2];
  logic [DW-1:0] rsp_data  [2];
  logic [AW-1:0] rsp_addr  [2];

  ent_t sb [2][$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_err    = 0;

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_line(input logic [AW-1:0] a);
    logic [31:0] w;
    w = 32'hA5A5_A5A5 ^ (32'(a ^ 9'd5) * 32'h0101_0101);
    return {16{w}};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [AW-1:0] ma1;
    logic [AW-1:0] ma2;

    dual_port_memory_reader #(
      .MEMORY_WIDTH (DW),
      .MEMORY_DEPTH (512),
      .READ_LATENCY (LAT[g]),
      .BUFFER_DEPTH (DEPTH[g])
    ) u_dut (
      .CLK              (clk),
      .RSTN             (rstn),
      .FLUSH            (flush),
      .REQ_VALID        (req_valid),
      .REQ_READY        (req_ready[g]),
      .REQ_ADDRESS      (req_address),
      .MEM_READ_ADDRESS (mem_addr[g]),
      .MEM_READ_ENBLE   (mem_en[g]),
      .MEM_DATA_OUT     (mem_dout[g]),
      .RSP_VALID        (rsp_valid[g]),
      .RSP_READY        (rsp_ready),
      .RSP_DATA         (rsp_data[g])
`ifdef DUAL_PORT_MEMORY_READER_ADDR_ECHO_EN
      ,
      .RSP_ADDRESS      (rsp_addr[g])
`endif
    );

`ifndef DUAL_PORT_MEMORY_READER_ADDR_ECHO_EN
    assign rsp_addr[g] = '0;
`endif

    // Memory with a fixed read latency: data for an address is presented LAT cycles later.
    always @(posedge clk) begin
      ma1 <= mem_addr[g];
      ma2 <= ma1;
    end
    assign mem_dout[g] = mem_line((LAT[g] == 2) ? ma2 : ma1);
  end

  task automatic check(input string tag, input int d, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL d%0d cyc%0d %s observed=%0h expected=%0h", d, cyc, tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare at the falling edge, then advance the scoreboard.
  task automatic step(input logic v, input logic [AW-1:0] a, input logic rr,
                      input logic fl, input logic rn);
    logic exp_ready;
    logic exp_valid;
    ent_t e;
    req_valid   = v;
    req_address = a;
    rsp_ready   = rr;
    flush       = fl;
    rstn        = rn;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      exp_ready = rn & ~fl & (sb[i].size() < DEPTH[i]);
      exp_valid = rn && (sb[i].size() > 0) && (sb[i][0].avail <= cyc);
      check("req_ready", i, DW'(req_ready[i]), DW'(exp_ready));
      check("mem_en", i, DW'(mem_en[i]), DW'(v & exp_ready));
      if (v & exp_ready) check("mem_addr", i, DW'(mem_addr[i]), DW'(a));
      check("rsp_valid", i, DW'(rsp_valid[i]), DW'(exp_valid));
      if (exp_valid) begin
        check("rsp_data", i, rsp_data[i], mem_line(sb[i][0].addr));
`ifdef DUAL_PORT_MEMORY_READER_ADDR_ECHO_EN
        check("rsp_addr", i, DW'(rsp_addr[i]), DW'(sb[i][0].addr));
`endif
      end
      if (!rn || fl) begin
        sb[i].delete();
      end else begin
        if (exp_valid && rr) void'(sb[i].pop_front());
        if (v && exp_ready) begin
          e.addr  = a;
          e.avail = cyc + LAT[i] + 1;
          sb[i].push_back(e);
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '0, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    rstn        = 1'b0;
    flush       = 1'b0;
    req_valid   = 1'b0;
    req_address = '0;
    rsp_ready   = 1'b1;
    @(posedge clk);
    #1;

    // Reset
    repeat (2) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
`ifdef DUAL_PORT_MEMORY_READER_ADDR_ECHO_EN
    for (int i = 0; i < 2; i++) check("rsp_addr_reset", i, DW'(rsp_addr[i]), '0);
`endif

    // Single read of line 5
    step(1'b1, 9'd5, 1'b1, 1'b0, 1'b1);
    idle(5);

    // Streaming 0..15 at full rate
    for (int a = 0; a < 16; a++) step(1'b1, AW'(a), 1'b1, 1'b0, 1'b1);
    idle(6);

    // Backpressure: fill the credits, then drain
    repeat (8) step(1'b1, AW'($urandom), 1'b0, 1'b0, 1'b1);
    repeat (8) step(1'b0, '0, 1'b1, 1'b0, 1'b1);

    // Flush while two reads are in flight, then one clean read
    step(1'b1, 9'd1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 9'd2, 1'b1, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1, 1'b1);
    idle(4);
    step(1'b1, 9'd3, 1'b1, 1'b0, 1'b1);
    idle(5);

    // Reset mid-stream with buffered and in-flight reads
    repeat (4) step(1'b1, AW'($urandom), 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    repeat (6) step(1'b1, AW'($urandom), 1'b0, 1'b0, 1'b1);
    idle(8);

    // Back-to-back 7 then 9
    step(1'b1, 9'd7, 1'b1, 1'b0, 1'b1);
    step(1'b1, 9'd9, 1'b1, 1'b0, 1'b1);
    idle(5);

    // Randomized traffic with occasional flush and reset
    repeat (400) begin
      step($urandom_range(0, 3) != 0, AW'($urandom), $urandom_range(0, 9) < 7,
           $urandom_range(0, 99) < 3, $urandom_range(0, 99) >= 1);
    end
    idle(8);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
